aos_rq_serializer: RTL

- N_CH-channel AXI read/write address-request serializer for the AOS translation path.
- Merges every channel's AR and AW streams into one ordered request FIFO. The TLB lookup stage pops that FIFO.
- Fair arbitration at two levels: round-robin across channels, and per-channel read/write alternation that advances only on an actual grant.
- Widths and FIFO depth are parametrised.

---
 rtl/aos_rq_serializer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/aos_rq_serializer.sv
// -----------------------------------------------------------------------------
// aos_rq_serializer
//
// Collects the AR and AW address requests of N_CH virtual channels into one
// ordered request FIFO that the TLB lookup stage pops.
//
// Arbitration has two levels:
//   - round-robin across channels: the scan starts at rr_ch and moves one past
//     the channel that was last granted;
//   - per-channel read/write alternation (rw_pref): this only matters when a
//     channel has both AR and AW valid, and it flips only when a grant happens.
// At most one request is accepted per cycle. No request is accepted while the
// FIFO is full, and a full FIFO is never bypassed by a pop in the same cycle.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   ar_* / aw_*           per-channel read/write request handshakes; the
//                         packed fields of channel c sit in slice c
//   rq_valid/rq_ready     show-ahead FIFO head handshake (registered outputs)
//   rq_is_read, rq_ch,
//   rq_id, rq_addr,
//   rq_len, rq_size       fields of the head entry
//   rq_count              FIFO occupancy, 0..2^FIFO_LD
//
// Optional build macro AOS_RQ_SERIALIZER_STATS_EN adds the free-running
// counters stat_rd_grants, stat_wr_grants and stat_full_stalls.
// -----------------------------------------------------------------------------
module aos_rq_serializer #(
    parameter int N_CH    = 4,
    parameter int ID_W    = 16,
    parameter int ADDR_W  = 64,
    parameter int LEN_W   = 8,
    parameter int SIZE_W  = 3,
    parameter int FIFO_LD = 6,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [N_CH-1:0]          ar_valid,
    output logic [N_CH-1:0]          ar_ready,
    input  logic [N_CH*ID_W-1:0]     ar_id,
    input  logic [N_CH*ADDR_W-1:0]   ar_addr,
    input  logic [N_CH*LEN_W-1:0]    ar_len,
    input  logic [N_CH*SIZE_W-1:0]   ar_size,

    input  logic [N_CH-1:0]          aw_valid,
    output logic [N_CH-1:0]          aw_ready,
    input  logic [N_CH*ID_W-1:0]     aw_id,
    input  logic [N_CH*ADDR_W-1:0]   aw_addr,
    input  logic [N_CH*LEN_W-1:0]    aw_len,
    input  logic [N_CH*SIZE_W-1:0]   aw_size,

    output logic                     rq_valid,
    input  logic                     rq_ready,
    output logic                     rq_is_read,
    output logic [CH_W-1:0]          rq_ch,
    output logic [ID_W-1:0]          rq_id,
    output logic [ADDR_W-1:0]        rq_addr,
    output logic [LEN_W-1:0]         rq_len,
    output logic [SIZE_W-1:0]        rq_size,
    output logic [FIFO_LD:0]         rq_count
`ifdef AOS_RQ_SERIALIZER_STATS_EN
    ,
    output logic [31:0]              stat_rd_grants,
    output logic [31:0]              stat_wr_grants,
    output logic [31:0]              stat_full_stalls
`endif
);

    localparam int DEPTH = 1 << FIFO_LD;
    localparam int ENT_W = 1 + CH_W + ID_W + ADDR_W + LEN_W + SIZE_W;

    // Channel index reached by stepping off positions upward from base, mod N_CH.
    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N_CH) ? (s - N_CH) : s;
    endfunction

    // Arbitration state
    logic [CH_W-1:0]    rr_ch_q, rr_ch_d;
    logic [N_CH-1:0]    rw_pref_q, rw_pref_d;

    // FIFO state
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [FIFO_LD-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LD-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LD:0]   count_q, count_d;
    logic               rq_valid_q, rq_valid_d;
    logic [ENT_W-1:0]   head_q, head_d;

    // Arbitration results
    logic [N_CH-1:0]    req;
    logic               sel_any;
    logic [CH_W-1:0]    sel_ch;
    logic               sel_rd;
    logic               full;
    logic               grant;
    logic               pop;
    logic [ENT_W-1:0]   push_ent;
    logic [FIFO_LD:0]   remain;

    assign full = (count_q == (FIFO_LD+1)'(DEPTH));
    assign pop  = rq_valid_q && rq_ready;

    // Channel scan and read/write choice
    always_comb begin
        req     = ar_valid | aw_valid;
        sel_any = 1'b0;
        sel_ch  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!sel_any && req[wrap_idx(int'(rr_ch_q), i)]) begin
                sel_any = 1'b1;
                sel_ch  = CH_W'(wrap_idx(int'(rr_ch_q), i));
            end
        end
        if (ar_valid[sel_ch] && aw_valid[sel_ch]) begin
            sel_rd = rw_pref_q[sel_ch];
        end else begin
            sel_rd = ar_valid[sel_ch];
        end
    end

    // A grant needs room in the FIFO; a pop in the same cycle does not count.
    // Readies stay low while reset is held.
    assign grant = sel_any && !full && !rst;

    always_comb begin
        ar_ready = '0;
        aw_ready = '0;
        if (grant) begin
            if (sel_rd) begin
                ar_ready[sel_ch] = 1'b1;
            end else begin
                aw_ready[sel_ch] = 1'b1;
            end
        end
    end

    always_comb begin
        if (sel_rd) begin
            push_ent = {1'b1, sel_ch,
                        ar_id[int'(sel_ch)*ID_W +: ID_W],
                        ar_addr[int'(sel_ch)*ADDR_W +: ADDR_W],
                        ar_len[int'(sel_ch)*LEN_W +: LEN_W],
                        ar_size[int'(sel_ch)*SIZE_W +: SIZE_W]};
        end else begin
            push_ent = {1'b0, sel_ch,
                        aw_id[int'(sel_ch)*ID_W +: ID_W],
                        aw_addr[int'(sel_ch)*ADDR_W +: ADDR_W],
                        aw_len[int'(sel_ch)*LEN_W +: LEN_W],
                        aw_size[int'(sel_ch)*SIZE_W +: SIZE_W]};
        end
    end

    // Next-state for arbitration pointers; nothing moves without a grant
    always_comb begin
        rr_ch_d   = rr_ch_q;
        rw_pref_d = rw_pref_q;
        if (grant) begin
            rr_ch_d = (sel_ch == CH_W'(N_CH-1)) ? '0 : (sel_ch + CH_W'(1));
            rw_pref_d[sel_ch] = !sel_rd;
        end
    end

    // Next-state for the FIFO and its registered head
    always_comb begin
        wr_ptr_d = grant ? (wr_ptr_q + FIFO_LD'(1)) : wr_ptr_q;
        rd_ptr_d = pop   ? (rd_ptr_q + FIFO_LD'(1)) : rd_ptr_q;
        count_d  = count_q;
        if (grant && !pop) begin
            count_d = count_q + (FIFO_LD+1)'(1);
        end else if (!grant && pop) begin
            count_d = count_q - (FIFO_LD+1)'(1);
        end
        rq_valid_d = (count_d != '0);

        // Entries left in storage after this cycle's pop decide where the
        // next head comes from: the stored entry at rd_ptr_d, or the
        // entry being pushed right now when nothing older remains.
        remain = pop ? (count_q - (FIFO_LD+1)'(1)) : count_q;
        if (count_d == '0) begin
            head_d = head_q;
        end else if (remain == '0) begin
            head_d = push_ent;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ch_q    <= '0;
            rw_pref_q  <= '1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rq_valid_q <= 1'b0;
            head_q     <= '0;
        end else begin
            rr_ch_q    <= rr_ch_d;
            rw_pref_q  <= rw_pref_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rq_valid_q <= rq_valid_d;
            head_q     <= head_d;
        end
    end

    // Storage holds only data; occupancy is tracked by the pointers above
    always_ff @(posedge clk) begin
        if (grant) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    assign rq_valid = rq_valid_q;
    assign {rq_is_read, rq_ch, rq_id, rq_addr, rq_len, rq_size} = head_q;
    assign rq_count = count_q;

`ifdef AOS_RQ_SERIALIZER_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_rd_d    = stat_rd_q;
        stat_wr_d    = stat_wr_q;
        stat_stall_d = stat_stall_q;
        if (grant && sel_rd) begin
            stat_rd_d = stat_rd_q + 32'd1;
        end
        if (grant && !sel_rd) begin
            stat_wr_d = stat_wr_q + 32'd1;
        end
        if (full && (|req)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q    <= '0;
            stat_wr_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_rd_q    <= stat_rd_d;
            stat_wr_q    <= stat_wr_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_rd_grants   = stat_rd_q;
    assign stat_wr_grants   = stat_wr_q;
    assign stat_full_stalls = stat_stall_q;
`endif

endmodule
